// File: rtl/lane_serializer_if.sv
// lane_serializer_if: word-in / lane-out handshake bundle for lane_serializer.
interface lane_serializer_if #(
    parameter int LANE_W    = 5,
    parameter int NUM_LANES = 10,
    parameter int SHIFT_W   = 3
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANE_W*NUM_LANES-1:0] in_word;
    logic [SHIFT_W-1:0]          in_shift;
    logic                        in_word_ok;
    logic                        lane_valid;
    logic                        lane_ready;
    logic [LANE_W-1:0]           lane_data;
    logic [3:0]                  lane_idx;
    logic                        lane_last;

    modport slave (
        input  in_valid, in_word, in_shift, in_word_ok, lane_ready,
        output in_ready, lane_valid, lane_data, lane_idx, lane_last
    );

    modport master (
        output in_valid, in_word, in_shift, in_word_ok, lane_ready,
        input  in_ready, lane_valid, lane_data, lane_idx, lane_last
    );
endinterface

// File: rtl/lane_serializer.sv
// lane_serializer: emits the meaningful lanes of a shifted word, LSB lane first, one per cycle.
// Optional saturating drop counter (drop_cnt/drop_clr) under LANE_SERIALIZER_DROP_CNT_EN.
module lane_serializer #(
    parameter int LANE_W    = 5,
    parameter int NUM_LANES = 10,
    parameter int SHIFT_W   = 3
) (
    input logic clk,
    input logic rst_n,
    lane_serializer_if.slave bus
`ifdef LANE_SERIALIZER_DROP_CNT_EN
    ,
    input  logic       drop_clr,
    output logic [7:0] drop_cnt
`endif
);
    localparam int MAX_SHIFT = 4;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state_q;
    logic [LANE_W*NUM_LANES-1:0] word_q;
    logic [3:0]                  cnt_q, cnt_d, idx_q, idx_d;
    logic                        valid_q, last_q;
    logic [LANE_W-1:0]           data_q;
    logic                        good, finish, accept;

    assign good   = bus.in_word_ok && (bus.in_shift <= SHIFT_W'(MAX_SHIFT));
    assign finish = valid_q && last_q && bus.lane_ready;
    // Ready during the final lane transfer lets the next word follow with no bubble.
    assign bus.in_ready = (state_q == IDLE) || finish;
    assign accept = bus.in_valid && bus.in_ready;
    assign cnt_d  = 4'(NUM_LANES) - 4'(bus.in_shift);
    assign idx_d  = idx_q + 4'd1;

    assign bus.lane_valid = valid_q;
    assign bus.lane_data  = data_q;
    assign bus.lane_idx   = idx_q;
    assign bus.lane_last  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (state_q == IDLE || finish) begin
            if (accept && good) begin
                state_q <= SEND;
                word_q  <= bus.in_word;
                cnt_q   <= cnt_d;
                idx_q   <= '0;
                valid_q <= 1'b1;
                data_q  <= bus.in_word[LANE_W-1:0];
                last_q  <= (cnt_d == 4'd1);
            end else begin
                state_q <= IDLE;
                idx_q   <= '0;
                valid_q <= 1'b0;
                data_q  <= '0;
                last_q  <= 1'b0;
            end
        end else if (bus.lane_ready) begin
            idx_q  <= idx_d;
            data_q <= word_q[idx_d*LANE_W +: LANE_W];
            last_q <= (idx_d == cnt_q - 4'd1);
        end
    end

`ifdef LANE_SERIALIZER_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_q <= '0;
        else if (drop_clr)
            drop_q <= '0;
        else if (accept && !good && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: directed checks of lane_serializer ordering, stalls, back-to-back words, drops and reset.
module tb_lane_serializer;
    typedef struct packed {logic [3:0] idx; logic [4:0] data; logic last;} lane_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    lane_t q[$];

    lane_serializer_if bus ();
`ifdef LANE_SERIALIZER_DROP_CNT_EN
    logic drop_clr = 1'b0;
    logic [7:0] drop_cnt;
`endif

    lane_serializer dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef LANE_SERIALIZER_DROP_CNT_EN
        ,
        .drop_clr(drop_clr),
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && bus.lane_valid && bus.lane_ready) q.push_back({bus.lane_idx, bus.lane_data, bus.lane_last});

    function automatic logic [49:0] mk(int base, int n);
        logic [49:0] w;
        for (int i = 0; i < 10; i++) w[i*5 +: 5] = (i < n) ? 5'(base + i) : 5'h1f;
        return w;
    endfunction

    function automatic lane_t cur();
        return {bus.lane_idx, bus.lane_data, bus.lane_last};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
        tests++; if (bus.lane_valid !== 1'b0) begin fails++; $display("FAIL reset lane_valid: got %b want 0", bus.lane_valid); end
        tests++; if (cur() !== lane_t'(0)) begin fails++; $display("FAIL reset lane fields: got %h want 000", cur()); end
        rst_n = 1'b1;
    endtask

    task automatic test_full();
        lane_t e;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = mk(0, 10); bus.in_shift = 3'd0; bus.in_word_ok = 1'b1; bus.lane_ready = 1'b1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL full idle in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            e = {4'(i), 5'(i), i == 9};
            tests++; if (bus.lane_valid !== 1'b1 || cur() !== e) begin fails++; $display("FAIL full lane %0d: got v=%b %h want v=1 %h", i, bus.lane_valid, cur(), e); end
            tests++; if (bus.in_ready !== (i == 9)) begin fails++; $display("FAIL full in_ready lane %0d: got %b want %b", i, bus.in_ready, i == 9); end
            @(negedge clk);
        end
        tests++; if (bus.lane_valid !== 1'b0) begin fails++; $display("FAIL full end lane_valid: got %b want 0", bus.lane_valid); end
    endtask

    task automatic test_shift4();
        lane_t e;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = mk(17, 6); bus.in_shift = 3'd4; bus.in_word_ok = 1'b1; bus.lane_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            e = {4'(i), 5'(17 + i), i == 5};
            tests++; if (bus.lane_valid !== 1'b1 || cur() !== e) begin fails++; $display("FAIL shift4 lane %0d: got v=%b %h want v=1 %h", i, bus.lane_valid, cur(), e); end
            @(negedge clk);
        end
        tests++; if (bus.lane_valid !== 1'b0) begin fails++; $display("FAIL shift4 fill lane emitted: got v=%b %h want v=0", bus.lane_valid, cur()); end
    endtask

    task automatic test_stall();
        logic [3:0] pat = 4'b1001;
        logic prev_ready = 1'b1;
        lane_t prev = '0;
        lane_t e;
        q.delete();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = mk(3, 8); bus.in_shift = 3'd2; bus.in_word_ok = 1'b1; bus.lane_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 40 && q.size() < 8; c++) begin
            if (!prev_ready && bus.lane_valid) begin
                tests++; if (cur() !== prev) begin fails++; $display("FAIL stall hold cycle %0d: got %h want %h", c, cur(), prev); end
            end
            prev = cur();
            bus.lane_ready = pat[c%4];
            prev_ready = bus.lane_ready;
            @(negedge clk);
        end
        tests++; if (q.size() != 8) begin fails++; $display("FAIL stall lane count: got %0d want 8", q.size()); end
        for (int i = 0; i < q.size() && i < 8; i++) begin
            e = {4'(i), 5'(3 + i), i == 7};
            tests++; if (q[i] !== e) begin fails++; $display("FAIL stall lane %0d: got %h want %h", i, q[i], e); end
        end
        bus.lane_ready = 1'b1;
        tests++; if (bus.lane_valid !== 1'b0) begin fails++; $display("FAIL stall end lane_valid: got %b want 0", bus.lane_valid); end
    endtask

    task automatic test_back_to_back();
        int ready_at = -1;
        lane_t e;
        q.delete();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = mk(1, 7); bus.in_shift = 3'd3; bus.in_word_ok = 1'b1; bus.lane_ready = 1'b1;
        @(negedge clk);
        bus.in_word = mk(10, 9); bus.in_shift = 3'd1;
        for (int k = 0; k < 16; k++) begin
            tests++; if (bus.lane_valid !== 1'b1) begin fails++; $display("FAIL b2b bubble cycle %0d: got v=%b want v=1", k, bus.lane_valid); end
            if (bus.in_ready && ready_at < 0) ready_at = k;
            @(negedge clk);
            if (ready_at >= 0) bus.in_valid = 1'b0;
        end
        tests++; if (ready_at != 6) begin fails++; $display("FAIL b2b in_ready cycle: got %0d want 6", ready_at); end
        tests++; if (bus.lane_valid !== 1'b0) begin fails++; $display("FAIL b2b end lane_valid: got %b want 0", bus.lane_valid); end
        tests++; if (q.size() != 16) begin fails++; $display("FAIL b2b lane count: got %0d want 16", q.size()); end
        for (int i = 0; i < q.size() && i < 16; i++) begin
            e = (i < 7) ? {4'(i), 5'(1 + i), i == 6} : {4'(i - 7), 5'(3 + i), i == 15};
            tests++; if (q[i] !== e) begin fails++; $display("FAIL b2b lane %0d: got %h want %h", i, q[i], e); end
        end
    endtask

    task automatic test_drop();
        q.delete();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = mk(0, 10); bus.in_shift = 3'd0; bus.in_word_ok = 1'b0; bus.lane_ready = 1'b1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL drop ok0 in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_word_ok = 1'b1; bus.in_shift = 3'd6;
        tests++; if (bus.in_ready !== 1'b1 || bus.lane_valid !== 1'b0) begin fails++; $display("FAIL drop after ok0: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.lane_valid); end
        @(negedge clk);
        bus.in_valid = 1'b0;
`ifdef LANE_SERIALIZER_DROP_CNT_EN
        tests++; if (drop_cnt !== 8'd2) begin fails++; $display("FAIL drop_cnt two: got %0d want 2", drop_cnt); end
`endif
        for (int c = 0; c < 3; c++) begin
            tests++; if (bus.in_ready !== 1'b1 || bus.lane_valid !== 1'b0) begin fails++; $display("FAIL drop idle %0d: got rdy=%b v=%b want rdy=1 v=0", c, bus.in_ready, bus.lane_valid); end
            @(negedge clk);
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL drop lanes emitted: got %0d want 0", q.size()); end
`ifdef LANE_SERIALIZER_DROP_CNT_EN
        bus.in_valid = 1'b1; bus.in_word_ok = 1'b0;
        repeat (300) @(negedge clk);
        bus.in_valid = 1'b0;
        tests++; if (drop_cnt !== 8'd255) begin fails++; $display("FAIL drop_cnt saturate: got %0d want 255", drop_cnt); end
        bus.in_valid = 1'b1; drop_clr = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; drop_clr = 1'b0;
        tests++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL drop_cnt clear: got %0d want 0", drop_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = mk(0, 10); bus.in_shift = 3'd0; bus.in_word_ok = 1'b1; bus.lane_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 20 && bus.lane_idx != 4'd4; c++) @(negedge clk);
        tests++; if (bus.lane_idx !== 4'd4 || bus.lane_valid !== 1'b1) begin fails++; $display("FAIL rstmid reach idx4: got idx=%0d v=%b want idx=4 v=1", bus.lane_idx, bus.lane_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.lane_valid !== 1'b0 || cur() !== lane_t'(0)) begin fails++; $display("FAIL rstmid abort: got v=%b %h want v=0 000", bus.lane_valid, cur()); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rstmid in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_word = mk(20, 10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests++; if (bus.lane_valid !== 1'b1 || cur() !== lane_t'({4'd0, 5'd20, 1'b0})) begin fails++; $display("FAIL rstmid restart: got v=%b %h want v=1 028", bus.lane_valid, cur()); end
        repeat (10) @(negedge clk);
        tests++; if (q.size() != 10 || q[q.size()-1] !== lane_t'({4'd9, 5'd29, 1'b1})) begin fails++; $display("FAIL rstmid drain: got n=%0d want n=10 ending 9/29/last", q.size()); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_word = '0; bus.in_shift = '0; bus.in_word_ok = 1'b0; bus.lane_ready = 1'b0;
        test_reset();
        test_full();
        test_shift4();
        test_stall();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Downstream consumer of the lane-granular right shifter.
- Accepts the shifter's 50-bit result as 10 lanes of 5 bits, together with the shift amount applied and the shifter's validity flag, over a valid/ready handshake.
- Emits the meaningful lanes one per cycle, LSB lane first, on a 5-bit valid/ready stream with a last marker.
- Words flagged invalid are discarded without producing output.

Parameters:
- LANE_W, 5, bits per lane.
- NUM_LANES, 10, lanes per input word; word width is LANE_W*NUM_LANES.
- SHIFT_W, 3, width of the shift-amount field.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word offered.
- in_ready  output  1  block can take a word this cycle.
- in_word  input  LANE_W*NUM_LANES  shifted word; lane i = bits [5i+4:5i].
- in_shift  input  SHIFT_W  lane shift applied upstream (0..4 meaningful).
- in_word_ok  input  1  upstream validity flag; 0 = word illegal (shift 5..7).
- lane_valid  output  1  lane_data holds a lane.
- lane_ready  input  1  sink accepts lane.
- lane_data  output  LANE_W  current lane.
- lane_idx  output  4  index of current lane within its word (0..9).
- lane_last  output  1  current lane is the final one of its word.

Behaviour:
- Accept occurs when in_valid & in_ready.
- Lane transfer occurs when lane_valid & lane_ready.
- Reset: state IDLE; in_ready=1; lane_valid=0; lane_data=0; lane_idx=0; lane_last=0; word register=0; lane count=0.
- Lane count for a word = NUM_LANES - in_shift, i.e. 10..6. The upper in_shift lanes are fill lanes and are never emitted.

States:
- IDLE
  - in_ready=1.
  - Accept with in_word_ok=1: register the word and the count; go to SEND with lane_idx=0. lane_valid rises the cycle after accept (1-cycle latency).
  - Accept with in_word_ok=0: word consumed and dropped; stay IDLE; no lane output.
- SEND
  - lane_valid=1. lane_data = registered lane[lane_idx]. lane_last = (lane_idx == count-1).
  - Transfer with lane_last=0: lane_idx increments.
  - Transfer with lane_last=1: word finished.
  - in_ready = lane_last & lane_ready (back-to-back).
    - Simultaneous last-transfer and accept of a good word: next cycle is SEND, lane_idx=0, new word.
    - Simultaneous last-transfer and accept of a bad word: go to IDLE.
    - Last transfer without accept: go to IDLE.

Output stability and throughput:
- While lane_valid=1 and lane_ready=0, lane_data, lane_idx and lane_last hold stable. No lane is skipped or repeated.
- Sustained throughput: one lane per cycle. A word of N lanes occupies exactly N cycles when lane_ready stays high.

Out-of-range shift:
- in_shift values 5..7 with in_word_ok=1 are treated as protocol errors: the word is dropped exactly as for in_word_ok=0.

Reset mid-operation:
- Asynchronous reset in SEND aborts the word immediately; outputs go to reset values with no partial completion.

Arithmetic:
- Lane count is computed in 4 bits; no wrap occurs for legal shifts.

Optional Feature:
- Macro LANE_SERIALIZER_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, 8 bits, reset 0.
  - Increments once per accepted dropped word (in_word_ok=0 or in_shift>4).
  - Saturates at 255.
  - Adds input drop_clr, 1 bit. Synchronous clear; when asserted with a drop in the same cycle, the result is 0.
- Undefined:
  - Neither port exists.
  - Drop behaviour is otherwise identical.

Test Plan:
- Reset, then in_word = lanes 0..9 holding values 0..9, in_shift=0, ok=1, lane_ready=1 -> lane_valid rises 1 cycle after accept; lane_data 0,1,..,9 on 10 consecutive cycles; lane_last only with value 9; in_ready high on that cycle.
- in_shift=4, lanes 0..5 = 0x11..0x16 (5-bit: 17..22), ok=1 -> exactly 6 lanes 17..22 emitted; lane_last on lane_idx=5; fill lanes never appear.
- lane_ready toggled 1,0,0,1 during a shift=2 word -> lane_data/lane_idx frozen while ready=0; 8 lanes total, no duplicates or gaps.
- Two good words offered back-to-back, shift=3 then shift=1, ready=1 -> 7 lanes then 9 lanes with no idle cycle between; in_ready pulses on the last lane of word 1.
- Word with ok=0, then a word with ok=1 and in_shift=6 -> no lane_valid; in_ready stays 1. With the macro defined, drop_cnt=2. 300 drops -> drop_cnt=255; drop_clr -> 0.
- rst_n asserted at lane_idx=4 of a 10-lane word -> lane_valid=0 immediately; after release in_ready=1 and the next word starts at lane_idx=0.
